// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stage enables/clears, operand
// forwarding selects, load-use bubbles, memory wait and single-step.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       addr_rs,
    input  logic [4:0]       addr_rt,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic [4:0]       regw_addr_exe,
    input  logic [4:0]       regw_addr_mem,
    input  logic [4:0]       regw_addr_wb,
    input  logic             wb_wen_exe,
    input  logic             wb_wen_mem,
    input  logic             wb_wen_wb,
    input  logic             is_load_exe,
    input  logic             is_load_mem,
    input  logic             is_store_mem,
    input  logic [4:0]       addr_rt_mem,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             run_mode,
    input  logic             step,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic [2:0]       fwd_a_ctrl,
    output logic [2:0]       fwd_b_ctrl,
    output logic             fwd_m_ctrl,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_RUN      = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_HALT     = 3'd3,
        S_STEP     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_mem_err;

    // Stage vectors ordered {if, id, exe, mem, wb}
    logic [4:0]        w_en;
    logic [4:0]        w_rst;
    logic              w_hazard;
    logic              w_adv;
    logic              w_timeout;
    logic              w_stall_inc;
    logic              w_wait_load;
    logic              w_wait_inc;
    logic              w_err_set;
    logic [2:0]        w_fwd_a;
    logic [2:0]        w_fwd_b;
    logic              w_fwd_m;

    // Youngest producer wins; a load still in MEM supplies mem_din
    function automatic logic [2:0] f_fwd(
        input logic       used,
        input logic [4:0] src
    );
        logic [2:0] sel;
        sel = 3'd0;
        if (used && src != 5'd0) begin
            if (wb_wen_exe && regw_addr_exe == src)
                sel = 3'd1;
            else if (wb_wen_mem && regw_addr_mem == src)
                sel = is_load_mem ? 3'd3 : 3'd2;
            else if (wb_wen_wb && regw_addr_wb == src)
                sel = 3'd4;
        end
        return sel;
    endfunction

    assign w_hazard = is_load_exe && wb_wen_exe
                   && regw_addr_exe != 5'd0
                   && ((rs_used && regw_addr_exe == addr_rs)
                    || (rt_used && regw_addr_exe == addr_rt));

    assign w_timeout = r_wait_cnt == WAIT_W'(MEM_TIMEOUT);

    // Forwarding selects, held at regfile while initialising
    always_comb begin
        w_fwd_a = 3'd0;
        w_fwd_b = 3'd0;
        w_fwd_m = 1'b0;
        if (r_state != S_INIT) begin
            w_fwd_a = f_fwd(rs_used, addr_rs);
            w_fwd_b = f_fwd(rt_used, addr_rt);
            w_fwd_m = is_store_mem && wb_wen_wb
                   && addr_rt_mem != 5'd0
                   && regw_addr_wb == addr_rt_mem;
        end
    end

    // Next state, stage controls and counter strobes
    always_comb begin
        w_next      = r_state;
        w_en        = 5'b00000;
        w_rst       = 5'b00000;
        w_adv       = 1'b0;
        w_stall_inc = 1'b0;
        w_wait_load = 1'b0;
        w_wait_inc  = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_rst  = 5'b11111;
                w_next = run_mode ? S_RUN : S_HALT;
            end
            S_RUN, S_STEP: begin
                if (mem_req && !mem_ack) begin
                    w_rst       = 5'b00001;
                    w_stall_inc = 1'b1;
                    w_wait_load = 1'b1;
                    w_next      = S_MEM_WAIT;
                end else begin
                    w_adv = 1'b1;
                    if (r_state == S_STEP || !run_mode)
                        w_next = S_HALT;
                    else
                        w_next = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack || w_timeout) begin
                    w_adv     = 1'b1;
                    w_err_set = !mem_ack;
                    w_next    = run_mode ? S_RUN : S_HALT;
                end else begin
                    w_rst       = 5'b00001;
                    w_stall_inc = 1'b1;
                    w_wait_inc  = 1'b1;
                end
            end
            S_HALT: begin
                if (step)
                    w_next = S_STEP;
                else if (run_mode)
                    w_next = S_RUN;
            end
            default: begin
                w_rst  = 5'b11111;
                w_next = S_INIT;
            end
        endcase
        if (w_adv) begin
            if (w_hazard) begin
                w_en        = 5'b00111;
                w_rst       = 5'b00100;
                w_stall_inc = 1'b1;
            end else if (branch_taken) begin
                w_en  = 5'b11111;
                w_rst = 5'b01000;
            end else begin
                w_en = 5'b11111;
            end
        end
    end

    // State register, wait/stall counters and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_load)
                r_wait_cnt <= WAIT_W'(1);
            else if (w_wait_inc)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_stall_inc && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_err_set)
                r_mem_err <= 1'b1;
        end
    end

    assign {if_en, id_en, exe_en, mem_en, wb_en}      = w_en;
    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = w_rst;
    assign fwd_a_ctrl = w_fwd_a;
    assign fwd_b_ctrl = w_fwd_b;
    assign fwd_m_ctrl = w_fwd_m;
    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random
// traffic, each cycle predicted by a behavioural model.
module tb_pipe_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    addr_rs, addr_rt;
    logic          rs_used, rt_used;
    logic [4:0]    regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic          wb_wen_exe, wb_wen_mem, wb_wen_wb;
    logic          is_load_exe, is_load_mem, is_store_mem;
    logic [4:0]    addr_rt_mem;
    logic          branch_taken, mem_req, mem_ack;
    logic          run_mode, step;
    logic          if_en, id_en, exe_en, mem_en, wb_en;
    logic          if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic [2:0]    fwd_a_ctrl, fwd_b_ctrl;
    logic          fwd_m_ctrl;
    logic [2:0]    state;
    logic [CW-1:0] stall_cnt;
    logic          mem_err;

    pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_rs(addr_rs), .addr_rt(addr_rt),
        .rs_used(rs_used), .rt_used(rt_used),
        .regw_addr_exe(regw_addr_exe),
        .regw_addr_mem(regw_addr_mem),
        .regw_addr_wb(regw_addr_wb),
        .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem),
        .wb_wen_wb(wb_wen_wb),
        .is_load_exe(is_load_exe), .is_load_mem(is_load_mem),
        .is_store_mem(is_store_mem), .addr_rt_mem(addr_rt_mem),
        .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .run_mode(run_mode), .step(step),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst),
        .mem_rst(mem_rst), .wb_rst(wb_rst),
        .fwd_a_ctrl(fwd_a_ctrl), .fwd_b_ctrl(fwd_b_ctrl),
        .fwd_m_ctrl(fwd_m_ctrl),
        .state(state), .stall_cnt(stall_cnt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] en;
        logic [4:0] rst;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       fm;
        int         st;
        int         stall;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Model state: mode 0 init,1 run,2 mem wait,3 halt,4 step
    int m_mode   = 0;
    int m_waited = 0;
    int m_stalls = 0;
    bit m_err    = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_fwd(logic used,
                                           logic [4:0] src);
        logic [4:0] a [3];
        logic       w [3];
        logic [2:0] c [3];
        a = '{regw_addr_exe, regw_addr_mem, regw_addr_wb};
        w = '{wb_wen_exe, wb_wen_mem, wb_wen_wb};
        c = '{3'd1, (is_load_mem ? 3'd3 : 3'd2), 3'd4};
        if (!used || src == 5'd0) return 3'd0;
        for (int i = 0; i < 3; i++)
            if (w[i] && a[i] == src) return c[i];
        return 3'd0;
    endfunction

    function automatic bit ref_hazard();
        if (!(is_load_exe && wb_wen_exe)) return 1'b0;
        if (regw_addr_exe == 5'd0) return 1'b0;
        return (rs_used && addr_rs == regw_addr_exe)
            || (rt_used && addr_rt == regw_addr_exe);
    endfunction

    // Predict this cycle's outputs, then step the model
    task automatic issue();
        exp_t e;
        int   nxt;
        bit   adv;
        bit   bump;
        e = '{default: 0};
        adv  = 1'b0;
        bump = 1'b0;
        if (!rst_n) begin
            e.rst    = 5'b11111;
            m_mode   = 0;
            m_waited = 0;
            m_stalls = 0;
            m_err    = 1'b0;
            q.push_back(e);
            return;
        end
        e.st    = m_mode;
        e.stall = m_stalls;
        e.err   = m_err;
        nxt     = m_mode;
        if (m_mode != 0) begin
            e.fa = ref_fwd(rs_used, addr_rs);
            e.fb = ref_fwd(rt_used, addr_rt);
            e.fm = is_store_mem && wb_wen_wb
                && addr_rt_mem != 5'd0
                && regw_addr_wb == addr_rt_mem;
        end
        case (m_mode)
            0: begin
                e.rst = 5'b11111;
                nxt   = run_mode ? 1 : 3;
            end
            1, 4: begin
                if (mem_req && !mem_ack) begin
                    e.rst    = 5'b00001;
                    bump     = 1'b1;
                    m_waited = 1;
                    nxt      = 2;
                end else begin
                    adv = 1'b1;
                    nxt = (m_mode == 4 || !run_mode) ? 3 : 1;
                end
            end
            2: begin
                if (mem_ack || m_waited == TO) begin
                    adv = 1'b1;
                    if (!mem_ack) m_err = 1'b1;
                    nxt = run_mode ? 1 : 3;
                end else begin
                    e.rst    = 5'b00001;
                    bump     = 1'b1;
                    m_waited = m_waited + 1;
                end
            end
            default: begin
                nxt = step ? 4 : (run_mode ? 1 : 3);
            end
        endcase
        if (adv) begin
            if (ref_hazard()) begin
                e.en  = 5'b00111;
                e.rst = 5'b00100;
                bump  = 1'b1;
            end else if (branch_taken) begin
                e.en  = 5'b11111;
                e.rst = 5'b01000;
            end else begin
                e.en = 5'b11111;
            end
        end
        if (bump)
            m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
        m_mode = nxt;
        q.push_back(e);
    endtask

    task automatic quiet();
        rst_n         = 1'b1;
        addr_rs       = 5'd0;
        addr_rt       = 5'd0;
        rs_used       = 1'b0;
        rt_used       = 1'b0;
        regw_addr_exe = 5'd0;
        regw_addr_mem = 5'd0;
        regw_addr_wb  = 5'd0;
        wb_wen_exe    = 1'b0;
        wb_wen_mem    = 1'b0;
        wb_wen_wb     = 1'b0;
        is_load_exe   = 1'b0;
        is_load_mem   = 1'b0;
        is_store_mem  = 1'b0;
        addr_rt_mem   = 5'd0;
        branch_taken  = 1'b0;
        mem_req       = 1'b0;
        mem_ack       = 1'b0;
        run_mode      = 1'b1;
        step          = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        quiet();
    endtask

    function automatic int en_vec();
        return int'({if_en, id_en, exe_en, mem_en, wb_en});
    endfunction

    function automatic int rst_vec();
        return int'({if_rst, id_rst, exe_rst, mem_rst, wb_rst});
    endfunction

    // Monitor: pop the prediction for each presented cycle
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_enables", en_vec(), int'(e.en));
                chk("sb_clears", rst_vec(), int'(e.rst));
                chk("sb_fwd_a", int'(fwd_a_ctrl), int'(e.fa));
                chk("sb_fwd_b", int'(fwd_b_ctrl), int'(e.fb));
                chk("sb_fwd_m", int'(fwd_m_ctrl), int'(e.fm));
                chk("sb_state", int'(state), e.st);
                chk("sb_stall_cnt", int'(stall_cnt), e.stall);
                chk("sb_mem_err", int'(mem_err), int'(e.err));
            end
        end
    end

    task automatic do_reset(bit rm);
        next_cycle(); rst_n = 1'b0; run_mode = rm; issue();
        next_cycle(); rst_n = 1'b0; run_mode = rm; issue();
        next_cycle(); run_mode = rm; issue();
    endtask

    initial begin : driver
        int n_full;
        quiet();
        rst_n = 1'b0;

        next_cycle(); rst_n = 1'b0; issue();
        @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_clears", rst_vec(), 31);
        chk("rst_enables", en_vec(), 0);
        next_cycle(); issue();
        @(negedge clk);
        chk("init_cycle_en", en_vec(), 0);
        next_cycle(); issue();
        @(negedge clk);
        chk("first_advance", en_vec(), 31);

        next_cycle();
        is_load_exe = 1'b1; wb_wen_exe = 1'b1;
        regw_addr_exe = 5'd5; addr_rs = 5'd5; rs_used = 1'b1;
        issue();
        @(negedge clk);
        chk("lu_if_en", int'(if_en), 0);
        chk("lu_exe_rst", int'(exe_rst), 1);
        next_cycle();
        is_load_mem = 1'b1; wb_wen_mem = 1'b1;
        regw_addr_mem = 5'd5; addr_rs = 5'd5; rs_used = 1'b1;
        issue();
        @(negedge clk);
        chk("lu_fwd_a", int'(fwd_a_ctrl), 3);
        chk("lu_stall_cnt", int'(stall_cnt), 1);

        next_cycle();
        wb_wen_exe = 1'b1; regw_addr_exe = 5'd7;
        wb_wen_mem = 1'b1; regw_addr_mem = 5'd7;
        addr_rt = 5'd7; rt_used = 1'b1;
        issue();
        @(negedge clk);
        chk("prio_exe", int'(fwd_b_ctrl), 1);
        next_cycle();
        wb_wen_exe = 1'b1; regw_addr_exe = 5'd0;
        wb_wen_mem = 1'b1; regw_addr_mem = 5'd7;
        addr_rt = 5'd7; rt_used = 1'b1;
        issue();
        @(negedge clk);
        chk("prio_mem", int'(fwd_b_ctrl), 2);
        next_cycle();
        wb_wen_wb = 1'b1; regw_addr_wb = 5'd7;
        addr_rt = 5'd7; rt_used = 1'b1;
        issue();
        @(negedge clk);
        chk("prio_wb", int'(fwd_b_ctrl), 4);
        next_cycle();
        wb_wen_wb = 1'b1; regw_addr_wb = 5'd7; addr_rt = 5'd7;
        issue();
        @(negedge clk);
        chk("unused_rt", int'(fwd_b_ctrl), 0);
        next_cycle();
        is_store_mem = 1'b1; wb_wen_wb = 1'b1;
        regw_addr_wb = 5'd9; addr_rt_mem = 5'd9;
        issue();
        @(negedge clk);
        chk("fwd_m", int'(fwd_m_ctrl), 1);

        next_cycle(); branch_taken = 1'b1; issue();
        @(negedge clk);
        chk("br_id_rst", int'(id_rst), 1);
        chk("br_if_en", int'(if_en), 1);
        next_cycle();
        branch_taken = 1'b1;
        is_load_exe = 1'b1; wb_wen_exe = 1'b1;
        regw_addr_exe = 5'd3; addr_rt = 5'd3; rt_used = 1'b1;
        issue();
        @(negedge clk);
        chk("br_hz_id_rst", int'(id_rst), 0);
        chk("br_hz_if_en", int'(if_en), 0);

        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); mem_req = 1'b1; mem_ack = (i == 3);
            issue();
            @(negedge clk);
            chk("mw_enables", en_vec(), (i == 3) ? 31 : 0);
            if (i == 1) chk("mw_state", int'(state), 2);
        end
        next_cycle(); issue();
        @(negedge clk);
        chk("mw_stall_cnt", int'(stall_cnt), 3);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); mem_req = 1'b1; issue();
            @(negedge clk);
            chk("to_err_early", int'(mem_err), 0);
        end
        next_cycle(); issue();
        @(negedge clk);
        chk("to_mem_err", int'(mem_err), 1);

        next_cycle(); mem_req = 1'b1; issue();
        next_cycle(); mem_req = 1'b1; issue();
        next_cycle(); mem_req = 1'b1; rst_n = 1'b0; issue();
        @(negedge clk);
        chk("rmw_state", int'(state), 0);
        chk("rmw_clears", rst_vec(), 31);
        chk("rmw_stall", int'(stall_cnt), 0);
        next_cycle(); rst_n = 1'b0; run_mode = 1'b0; issue();
        next_cycle(); run_mode = 1'b0; issue();

        n_full = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle(); run_mode = 1'b0;
            step = (i == 2 || i == 7);
            issue();
            @(negedge clk);
            if (en_vec() == 31) n_full++;
            if (i == 5) chk("ss_halt_between", int'(state), 3);
        end
        chk("ss_full_cycles", n_full, 2);

        for (int i = 0; i < 600; i++) begin
            next_cycle();
            rst_n         = ($urandom_range(0, 99) != 0);
            run_mode      = ($urandom_range(0, 9) != 0);
            step          = ($urandom_range(0, 7) == 0);
            addr_rs       = 5'($urandom_range(0, 3));
            addr_rt       = 5'($urandom_range(0, 3));
            rs_used       = 1'($urandom);
            rt_used       = 1'($urandom);
            regw_addr_exe = 5'($urandom_range(0, 3));
            regw_addr_mem = 5'($urandom_range(0, 3));
            regw_addr_wb  = 5'($urandom_range(0, 3));
            wb_wen_exe    = 1'($urandom);
            wb_wen_mem    = 1'($urandom);
            wb_wen_wb     = 1'($urandom);
            is_load_exe   = 1'($urandom);
            is_load_mem   = 1'($urandom);
            is_store_mem  = 1'($urandom);
            addr_rt_mem   = 5'($urandom_range(0, 3));
            branch_taken  = ($urandom_range(0, 3) == 0);
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_ack       = ($urandom_range(0, 4) == 0);
            issue();
        end

        next_cycle(); issue();
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of MEM_WAIT cycles before a forced advance.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have inputs addr_rs, addr_rt  in  5 each  source registers of the ID instruction.
REQ-006 SHALL have inputs rs_used, rt_used  in  1 each  marking the ID operand as actually read.
REQ-007 SHALL have inputs regw_addr_exe/mem/wb  in  5 each, wb_wen_exe/mem/wb  in  1 each, is_load_exe/mem  in  1 each, is_store_mem  in  1, addr_rt_mem  in  5.
REQ-008 SHALL have input branch_taken  in  1  (taken branch or jump resolved in ID).
REQ-009 SHALL have inputs mem_req  in  1 (MEM stage read or write) and mem_ack  in  1 (memory completes this cycle).
REQ-010 SHALL have inputs run_mode  in  1 (1 = free run, 0 = single-step) and step  in  1 (one-cycle pulse).
REQ-011 SHALL have outputs if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables.
REQ-012 SHALL have outputs if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  synchronous stage clears, active-high.
REQ-013 SHALL have outputs fwd_a_ctrl, fwd_b_ctrl  out  3 each and fwd_m_ctrl  out  1  forwarding selects.
REQ-014 SHALL have outputs state  out  3, stall_cnt  out  CNT_W, and mem_err  out  1 (sticky timeout flag).

Function
REQ-015 States SHALL be INIT=0, RUN=1, MEM_WAIT=2, HALT=3, STEP=4.
REQ-016 INIT SHALL assert all *_rst, deassert all *_en, and go to RUN if run_mode else HALT.
REQ-017 Forwarding select codes SHALL be:
- 0 = regfile
- 1 = alu_out_exe
- 2 = alu_out_mem
- 3 = mem_din
- 4 = regw_data_wb
REQ-018 Forwarding priority SHALL be EXE > MEM > WB.
- A match requires wen=1, equal address, and address != 0.
- A MEM match selects 3 if is_load_mem, else 2.
- No match, or rs_used/rt_used = 0, selects 0.
REQ-019 fwd_m_ctrl SHALL be 1 iff is_store_mem, wb_wen_wb, regw_addr_wb == addr_rt_mem, and addr_rt_mem != 0.
REQ-020 A load-use hazard SHALL be is_load_exe, wb_wen_exe, regw_addr_exe != 0, and regw_addr_exe matching a used rs/rt.
REQ-021 In RUN with a load-use hazard: if_en=0, id_en=0, exe_rst=1, mem_en=1, wb_en=1 (exactly one bubble); branch_taken SHALL be ignored that cycle.
REQ-022 In RUN with branch_taken and no hazard: all enables 1 and id_rst=1 (one-slot flush).
REQ-023 In RUN with mem_req=1 and mem_ack=0: all *_en=0, wb_rst=1, go to MEM_WAIT, wait_cnt=1.
REQ-024 In MEM_WAIT, freeze outputs SHALL match REQ-023, wait_cnt SHALL increment, and hazard/branch handling SHALL be suppressed.
REQ-025 On mem_ack in MEM_WAIT: one normal advance cycle (REQ-021/022 rules apply), then go to RUN if run_mode else HALT.
REQ-026 On wait_cnt == MEM_TIMEOUT without ack: set mem_err=1 and advance as if acked; mem_err SHALL clear only on reset.
REQ-027 In RUN with run_mode=0 and no MEM_WAIT entry: advance normally this cycle, then go to HALT.
REQ-028 HALT SHALL drive all *_en=0 and all *_rst=0.
- step=1 goes to STEP.
- run_mode=1 goes to RUN.
- step has priority when both are asserted.
REQ-029 STEP SHALL behave exactly as one RUN cycle, including MEM_WAIT entry, then go to HALT.
REQ-030 stall_cnt SHALL increment once per cycle with a hazard bubble or in MEM_WAIT, and SHALL saturate at all-ones.
REQ-031 mem_ack in RUN with mem_req=1 SHALL produce no stall; mem_ack with mem_req=0 SHALL be ignored.

Reset
REQ-032 While rst_n=0: state=INIT, all *_rst=1, all *_en=0, fwd_*=0, stall_cnt=0, wait_cnt=0, mem_err=0.
REQ-033 Asserting rst_n low mid-MEM_WAIT or mid-STEP SHALL abort immediately to REQ-032 values.
REQ-034 After rst_n rises, exactly one INIT cycle SHALL precede the first stage advance.

Verification
REQ-035 The bench SHALL cover load-use: is_load_exe=1, regw_addr_exe=5, addr_rs=5, rs_used=1 -> one cycle with if_en=0, exe_rst=1; next cycle with load in MEM -> fwd_a_ctrl=3; stall_cnt=1.
REQ-036 The bench SHALL cover priority: EXE and MEM both writing r7, addr_rt=7 -> fwd_b_ctrl=1; with regw_addr_exe=0 -> fwd_b_ctrl=2.
REQ-037 The bench SHALL cover branch: branch_taken=1, no hazard -> id_rst=1 and if_en=1 for one cycle; with a simultaneous hazard -> no flush that cycle.
REQ-038 The bench SHALL cover memory wait: mem_req=1, mem_ack low 3 cycles -> state=2, all *_en=0 for 3 cycles, then one advance, stall_cnt=3; with MEM_TIMEOUT=4 and no ack -> mem_err=1 after 4 cycles.
REQ-039 The bench SHALL cover single-step: run_mode=0, step pulses twice -> exactly two cycles with all *_en=1, HALT in between.
REQ-040 The bench SHALL cover reset mid-MEM_WAIT: rst_n low -> state=0, all *_rst=1 asynchronously, stall_cnt=0.
